// File: rtl/xosera_bus_ctrl_if.sv
// xosera_bus_ctrl_if
//  Bundles the m68k bus pin signals (after SB_IO) and the register-file
//  access signals handled by xosera_bus_ctrl. The slave modport is the
//  controller's view and the master modport is the surrounding
//  environment's view (pads plus register file).
//  Signal names keep the controller-relative _i/_o suffixes on both modports.
interface xosera_bus_ctrl_if;
    // bus pin side
    logic        bus_cs_n_i;
    logic        bus_rd_nwr_i;
    logic        bus_bytesel_i;
    logic [3:0]  bus_reg_num_i;
    logic [7:0]  bus_data_i;
    logic [7:0]  bus_data_o;
    // register write side
    logic        reg_wr_o;
    logic [3:0]  reg_wr_num_o;
    logic [15:0] reg_wr_data_o;
    // register read side (level request, one-clock ack)
    logic        reg_rd_o;
    logic [3:0]  reg_rd_num_o;
    logic        reg_rd_ack_i;
    logic [15:0] reg_rd_data_i;
    // status / debug
    logic        busy_o;
    logic [2:0]  dbg_state_o;

    modport slave (
        input  bus_cs_n_i,
        input  bus_rd_nwr_i,
        input  bus_bytesel_i,
        input  bus_reg_num_i,
        input  bus_data_i,
        output bus_data_o,
        output reg_wr_o,
        output reg_wr_num_o,
        output reg_wr_data_o,
        output reg_rd_o,
        output reg_rd_num_o,
        input  reg_rd_ack_i,
        input  reg_rd_data_i,
        output busy_o,
        output dbg_state_o
    );

    modport master (
        output bus_cs_n_i,
        output bus_rd_nwr_i,
        output bus_bytesel_i,
        output bus_reg_num_i,
        output bus_data_i,
        input  bus_data_o,
        input  reg_wr_o,
        input  reg_wr_num_o,
        input  reg_wr_data_o,
        input  reg_rd_o,
        input  reg_rd_num_o,
        output reg_rd_ack_i,
        output reg_rd_data_i,
        input  busy_o,
        input  dbg_state_o
    );
endinterface

// File: rtl/xosera_bus_ctrl.sv
// xosera_bus_ctrl
//  Turns asynchronous m68k 8-bit bus cycles into single-clock register
//  accesses for xosera_main. CS is synchronized; the remaining bus inputs
//  are sampled once, after a settle delay, while they are known stable.
//  Even-byte writes are held and merged with the following odd-byte write
//  into one 16-bit write strobe. Reads use a level req/ack handshake and
//  the returned byte is held on bus_data_o for the pad driver.
//
//  Optional feature macro: XOSERA_BUS_DEGLITCH_EN
//   defined   - a select needs synced CS low for two consecutive clocks
//               in IDLE (single-clock low pulses are ignored, +1 clock
//               of latency).
//   undefined - a single synced falling edge of CS starts the cycle.
//
//  Read handshake: reg_rd_o rises together with a stable reg_rd_num_o and
//  stays high (never retracted) until a clock where reg_rd_ack_i=1; that
//  clock reg_rd_data_i is valid and reg_rd_o drops on the following edge.
//  An ack while no request is pending is ignored.
module xosera_bus_ctrl #(
    parameter int SYNC_STAGES   = 2,   // 2..3
    parameter int SETTLE_CYCLES = 2    // 1..7
) (
    input  logic            clk,
    input  logic            reset_i,
    xosera_bus_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_WRITE    = 3'd2,
        ST_READ_REQ = 3'd3,
        ST_RELEASE  = 3'd4
    } state_t;

    localparam logic [2:0] SETTLE_INIT = 3'(SETTLE_CYCLES - 1);

    // CS synchronizer, preset to deselected
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_d;
    // marks synchronizer stages that hold a real pin sample (not the preset)
    logic [SYNC_STAGES-1:0] sync_vld_q;
    logic [SYNC_STAGES-1:0] sync_vld_d;
    // previous synced CS was a real, deselected (high) sample
    logic                   cs_prev_hi_q;
    logic                   cs_prev_hi_d;

    logic                   cs_sync;
    logic                   cs_fall;

    state_t                 state_q;
    logic [2:0]             settle_cnt_q;
    logic                   smp_bytesel_q;
    logic [7:0]             hold_q;
`ifdef XOSERA_BUS_DEGLITCH_EN
    logic                   fall_pend_q;
`endif

    logic                   busy_q;
    logic [7:0]             bus_data_q;
    logic                   reg_wr_q;
    logic [3:0]             reg_wr_num_q;
    logic [15:0]            reg_wr_data_q;
    logic                   reg_rd_q;
    logic [3:0]             reg_rd_num_q;

    assign cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], bus.bus_cs_n_i};
    assign sync_vld_d   = {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    assign cs_sync      = cs_sync_q[SYNC_STAGES-1];
    // a high sample left over from the reset preset never counts, so a CS
    // held low across reset release produces no falling edge
    assign cs_prev_hi_d = sync_vld_q[SYNC_STAGES-1] & cs_sync;
    assign cs_fall      = cs_prev_hi_q & ~cs_sync;

    // synchronize bus_cs_n_i and track the previous synced level
    always_ff @(posedge clk) begin
        if (reset_i) begin
            cs_sync_q    <= '1;
            sync_vld_q   <= '0;
            cs_prev_hi_q <= 1'b0;
        end else begin
            cs_sync_q    <= cs_sync_d;
            sync_vld_q   <= sync_vld_d;
            cs_prev_hi_q <= cs_prev_hi_d;
        end
    end

    // bus cycle sequencer: all outputs registered here
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            settle_cnt_q  <= 3'd0;
            smp_bytesel_q <= 1'b0;
            hold_q        <= 8'h00;
`ifdef XOSERA_BUS_DEGLITCH_EN
            fall_pend_q   <= 1'b0;
`endif
            busy_q        <= 1'b0;
            bus_data_q    <= 8'h00;
            reg_wr_q      <= 1'b0;
            reg_wr_num_q  <= 4'h0;
            reg_wr_data_q <= 16'h0000;
            reg_rd_q      <= 1'b0;
            reg_rd_num_q  <= 4'h0;
        end else begin
            // write strobe is a single-clock pulse unless re-armed below
            reg_wr_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
`ifdef XOSERA_BUS_DEGLITCH_EN
                    // falling edge arms, a second low clock confirms
                    if (fall_pend_q) begin
                        fall_pend_q <= 1'b0;
                        if (!cs_sync) begin
                            state_q      <= ST_SETTLE;
                            busy_q       <= 1'b1;
                            settle_cnt_q <= SETTLE_INIT;
                        end
                    end else if (cs_fall) begin
                        fall_pend_q <= 1'b1;
                    end
`else
                    if (cs_fall) begin
                        state_q      <= ST_SETTLE;
                        busy_q       <= 1'b1;
                        settle_cnt_q <= SETTLE_INIT;
                    end
`endif
                end

                ST_SETTLE: begin
                    // bus inputs are stable by the end of the settle time,
                    // so they are sampled directly without synchronizers
                    if (settle_cnt_q == 3'd0) begin
                        smp_bytesel_q <= bus.bus_bytesel_i;
                        if (bus.bus_rd_nwr_i) begin
                            state_q      <= ST_READ_REQ;
                            reg_rd_q     <= 1'b1;
                            reg_rd_num_q <= bus.bus_reg_num_i;
                        end else begin
                            // the WRITE state is the clock the strobe is high
                            state_q <= ST_WRITE;
                            if (bus.bus_bytesel_i) begin
                                reg_wr_q      <= 1'b1;
                                reg_wr_num_q  <= bus.bus_reg_num_i;
                                reg_wr_data_q <= {hold_q, bus.bus_data_i};
                            end else begin
                                hold_q <= bus.bus_data_i;
                            end
                        end
                    end else begin
                        settle_cnt_q <= settle_cnt_q - 3'd1;
                    end
                end

                ST_WRITE: begin
                    state_q <= ST_RELEASE;
                end

                ST_READ_REQ: begin
                    if (bus.reg_rd_ack_i) begin
                        reg_rd_q <= 1'b0;
                        state_q  <= ST_RELEASE;
                        // host already gave up the cycle: drop the data
                        if (!cs_sync) begin
                            bus_data_q <= smp_bytesel_q ? bus.reg_rd_data_i[7:0]
                                                        : bus.reg_rd_data_i[15:8];
                        end
                    end
                end

                ST_RELEASE: begin
                    // one bus cycle gives at most one register access
                    if (cs_sync) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bus_data_o    = bus_data_q;
    assign bus.reg_wr_o      = reg_wr_q;
    assign bus.reg_wr_num_o  = reg_wr_num_q;
    assign bus.reg_wr_data_o = reg_wr_data_q;
    assign bus.reg_rd_o      = reg_rd_q;
    assign bus.reg_rd_num_o  = reg_rd_num_q;
    assign bus.busy_o        = busy_q;
    assign bus.dbg_state_o   = state_q;

endmodule

// File: tb/tb_xosera_bus_ctrl.sv
// tb_xosera_bus_ctrl
//  Directed bench for xosera_bus_ctrl. A small model keeps the byte hold
//  value, the expected read byte and a queue of expected write strobes
//  (due cycle, register, word); one compare process checks every clock.
module tb_xosera_bus_ctrl;

    localparam int S  = 2;
    localparam int SC = 2;
`ifdef XOSERA_BUS_DEGLITCH_EN
    localparam int LAT = S + SC + 2;
`else
    localparam int LAT = S + SC + 1;
`endif
    localparam int W = 36;   // {due cycle[15:0], reg num[3:0], word[15:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    xosera_bus_ctrl_if bus_if();

    xosera_bus_ctrl #(
        .SYNC_STAGES  (S),
        .SETTLE_CYCLES(SC)
    ) dut (
        .clk    (clk),
        .reset_i(reset_i),
        .bus    (bus_if)
    );

    // ---------------- model / scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [7:0]   hold_m;
    logic [7:0]   exp_bus_data;
    int           n_tests = 0;
    int           n_fail  = 0;
    bit           chk_en  = 0;

    int           wr_count    = 0;
    logic [3:0]   last_wr_num;
    logic [15:0]  last_wr_data;
    int           last_wr_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // per-clock compare of write strobes and the held read byte
    always @(negedge clk) begin
        if (chk_en) begin
            logic [W-1:0] e;
            if (exp_q.size() > 0 && exp_q[0][35:20] == 16'(cyc)) begin
                e = exp_q.pop_front();
                check("wr_strobe", bus_if.reg_wr_o, 1);
                check("wr_num", bus_if.reg_wr_num_o, e[19:16]);
                check("wr_data", bus_if.reg_wr_data_o, e[15:0]);
            end else begin
                check("wr_quiet", bus_if.reg_wr_o, 0);
            end
            if (bus_if.reg_wr_o) begin
                wr_count++;
                last_wr_num  = bus_if.reg_wr_num_o;
                last_wr_data = bus_if.reg_wr_data_o;
                last_wr_cyc  = cyc;
            end
            check("bus_data", bus_if.bus_data_o, exp_bus_data);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (bus_if.busy_o == 1'b0) done = 1;
        end
        check("idle_timeout", done, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic bus_write(input logic [3:0] num, input logic bs, input logic [7:0] d,
                             input int low_cyc, input bit expect_access, output int start_cyc);
        @(posedge clk);
        #1;
        bus_if.bus_rd_nwr_i  = 1'b0;
        bus_if.bus_bytesel_i = bs;
        bus_if.bus_reg_num_i = num;
        bus_if.bus_data_i    = d;
        bus_if.bus_cs_n_i    = 1'b0;
        start_cyc = cyc;
        if (expect_access) begin
            if (bs) exp_q.push_back({16'(cyc + LAT), num, hold_m, d});
            else    hold_m = d;
        end
        repeat (low_cyc) @(posedge clk);
        #1 bus_if.bus_cs_n_i = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] num, input logic bs, input int delay,
                            input logic [15:0] d, input bit early);
        bit found = 0;
        int hi;
        @(posedge clk);
        #1;
        bus_if.bus_rd_nwr_i  = 1'b1;
        bus_if.bus_bytesel_i = bs;
        bus_if.bus_reg_num_i = num;
        bus_if.bus_cs_n_i    = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus_if.reg_rd_o) found = 1;
        end
        check("rd_req_seen", found, 1);
        if (!found) begin
            bus_if.bus_cs_n_i = 1'b1;
            wait_idle();
            return;
        end
        check("rd_num", bus_if.reg_rd_num_o, num);
        hi = 1;
        if (early) bus_if.bus_cs_n_i = 1'b1;
        repeat (delay) begin
            @(negedge clk);
            if (bus_if.reg_rd_o) hi++;
        end
        bus_if.reg_rd_ack_i  = 1'b1;
        bus_if.reg_rd_data_i = d;
        @(posedge clk);
        #1;
        bus_if.reg_rd_ack_i  = 1'b0;
        bus_if.reg_rd_data_i = 16'($urandom);
        if (!early) exp_bus_data = bs ? d[7:0] : d[15:8];
        @(negedge clk);
        check("rd_drop", bus_if.reg_rd_o, 0);
        check("rd_hi_len", hi, delay + 1);
        check("busy_after_ack", bus_if.busy_o, 1);
        if (early) begin
            @(negedge clk);
            check("busy_drop", bus_if.busy_o, 0);
        end else begin
            bus_if.bus_cs_n_i = 1'b1;
        end
        wait_idle();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int sc;
        int wc;
        bit quiet;

        reset_i              = 1'b1;
        bus_if.bus_cs_n_i    = 1'b1;
        bus_if.bus_rd_nwr_i  = 1'b0;
        bus_if.bus_bytesel_i = 1'b0;
        bus_if.bus_reg_num_i = 4'h0;
        bus_if.bus_data_i    = 8'h00;
        bus_if.reg_rd_ack_i  = 1'b0;
        bus_if.reg_rd_data_i = 16'h0000;
        hold_m               = 8'h00;
        exp_bus_data         = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr", bus_if.reg_wr_o, 0);
        check("rst_rd", bus_if.reg_rd_o, 0);
        check("rst_busy", bus_if.busy_o, 0);
        check("rst_bus_data", bus_if.bus_data_o, 8'h00);
        @(posedge clk);
        #1 reset_i = 1'b0;
        chk_en = 1;
        repeat (6) @(negedge clk);

        // odd-only write right after reset merges with the cleared hold byte
        bus_write(4'd5, 1'b1, 8'hAB, 12, 1, sc);
        wait_idle();
        check("odd_only_data", last_wr_data, 16'h00AB);
        check("odd_only_num", last_wr_num, 4'd5);
`ifdef XOSERA_BUS_DEGLITCH_EN
        check("wr_latency", last_wr_cyc - sc, 6);
`else
        check("wr_latency", last_wr_cyc - sc, 5);
`endif

        // even then odd to reg 3: exactly one strobe of 16'h1234
        wc = wr_count;
        bus_write(4'd3, 1'b0, 8'h12, 12, 1, sc);
        wait_idle();
        check("even_no_strobe", wr_count - wc, 0);
        bus_write(4'd3, 1'b1, 8'h34, 12, 1, sc);
        wait_idle();
        check("merge_count", wr_count - wc, 1);
        check("merge_data", last_wr_data, 16'h1234);
        check("merge_num", last_wr_num, 4'd3);

        // hold byte survives an odd write
        bus_write(4'd3, 1'b1, 8'h56, 12, 1, sc);
        wait_idle();
        check("hold_kept", last_wr_data, 16'h1256);

        // reads with a 4-clock ack delay, both byte lanes
        bus_read(4'd7, 1'b0, 4, 16'hBEEF, 0);
        check("rd_even_byte", bus_if.bus_data_o, 8'hBE);
        bus_read(4'd7, 1'b1, 4, 16'hBEEF, 0);
        check("rd_odd_byte", bus_if.bus_data_o, 8'hEF);

        // zero-wait ack
        bus_read(4'd1, 1'b0, 0, 16'hC3A5, 0);
        check("rd_zero_wait", bus_if.bus_data_o, 8'hC3);

        // stray ack while idle is ignored
        @(negedge clk);
        bus_if.reg_rd_ack_i  = 1'b1;
        bus_if.reg_rd_data_i = 16'hFFFF;
        @(posedge clk);
        #1 bus_if.reg_rd_ack_i = 1'b0;
        @(negedge clk);
        check("stray_ack", bus_if.bus_data_o, 8'hC3);

        // CS released long before the ack: data discarded
        bus_read(4'd4, 1'b1, 20, 16'h1111, 1);
        check("early_release_keep", bus_if.bus_data_o, 8'hC3);
        bus_read(4'd2, 1'b1, 2, 16'h7766, 0);
        check("after_early_read", bus_if.bus_data_o, 8'h66);

        // reset during READ_REQ with CS held low
        @(posedge clk);
        #1;
        bus_if.bus_rd_nwr_i  = 1'b1;
        bus_if.bus_bytesel_i = 1'b0;
        bus_if.bus_reg_num_i = 4'd2;
        bus_if.bus_cs_n_i    = 1'b0;
        begin
            bit found = 0;
            for (int i = 0; i < 40 && !found; i++) begin
                @(negedge clk);
                if (bus_if.reg_rd_o) found = 1;
            end
            check("rst_rd_req_seen", found, 1);
        end
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i      = 1'b0;
        hold_m       = 8'h00;
        exp_bus_data = 8'h00;
        @(negedge clk);
        check("rst_mid_rd", bus_if.reg_rd_o, 0);
        check("rst_mid_busy", bus_if.busy_o, 0);
        quiet = 1;
        repeat (15) begin
            @(negedge clk);
            if (bus_if.reg_rd_o || bus_if.busy_o) quiet = 0;
        end
        check("held_cs_no_access", quiet, 1);
        bus_if.bus_cs_n_i = 1'b1;
        repeat (6) @(negedge clk);

        // hold byte was cleared by reset
        bus_write(4'd9, 1'b1, 8'h5A, 12, 1, sc);
        wait_idle();
        check("post_rst_data", last_wr_data, 16'h005A);
        check("post_rst_num", last_wr_num, 4'd9);

        // single-clock CS glitch
        wc = wr_count;
`ifdef XOSERA_BUS_DEGLITCH_EN
        bus_write(4'd6, 1'b1, 8'h77, 1, 0, sc);
        repeat (30) @(negedge clk);
        wait_idle();
        check("glitch_ignored", wr_count - wc, 0);
`else
        bus_write(4'd6, 1'b1, 8'h77, 1, 1, sc);
        repeat (30) @(negedge clk);
        wait_idle();
        check("glitch_access", wr_count - wc, 1);
        check("glitch_data", last_wr_data, 16'h0077);
`endif

        check("wr_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
